lsu: RTL and testbench

- Memory-access stage directly downstream of the ALU stage (exu); consumes the ALU result as either a load/store address or a pass-through value.
- Issues one request at a time on a simple valid/ready memory port.
- For loads: aligns and sign/zero-extends read data. For stores: builds byte strobes.
- Hands the result, with rd tag, to writeback over a valid/ready output.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu.sv | 144 ++++++++++++++
 tb/tb_lsu.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_RESP = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B0   = 4'b0001;
    localparam logic [3:0] STRB_LO   = 4'b0011;
    localparam logic [3:0] STRB_HI   = 4'b1100;
    localparam logic [3:0] STRB_ALL  = 4'b1111;

    // Size 3 has no legal encoding and is reported like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lsb[0];
            SZ_W:    return lsb != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/strobes and load extraction/extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] st_data,
    input  logic [1:0]  size,
    input  logic [1:0]  lsb,
    input  logic        zero_ext,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data
);

    logic [7:0] lane;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = STRB_ALL;
        case (size)
            SZ_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = STRB_B0 << lsb;
            end
            SZ_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = lsb[1] ? STRB_HI : STRB_LO;
            end
            default: ;
        endcase
    end

    assign lane = 8'(rdata >> {lsb, 3'b000});

    always_comb begin
        case (size)
            SZ_B:    ld_data = {{24{~zero_ext & lane[7]}}, lane};
            SZ_H:    ld_data = lsb[1] ? {{16{~zero_ext & rdata[31]}}, rdata[31:16]}
                                      : {{16{~zero_ext & rdata[15]}}, rdata[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - memory-access stage: one outstanding load/store or pass-through op
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_res,
    input  logic [31:0] in_wdata,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen,
    output logic        out_misalign,
    output logic        out_timeout
);

    localparam bit               WD_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t           state;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic             cap_load;
    logic             cap_store;
    logic             cap_unsigned;
    logic [1:0]       cap_size;
    logic [CNT_W-1:0] wd_cnt;
    logic [31:0]      st_wdata;
    logic [3:0]       st_wstrb;
    logic [31:0]      ld_data;

    lsu_align u_align (
        .st_data  (cap_wdata),
        .size     (cap_size),
        .lsb      (cap_addr[1:0]),
        .zero_ext (cap_unsigned),
        .rdata    (mem_resp_rdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_data  (ld_data)
    );

    assign in_ready      = (state == ST_IDLE);
    assign mem_req_valid = (state == ST_REQ);
    assign out_valid     = (state == ST_OUT);
    assign mem_req_addr  = {cap_addr[31:2], 2'b00};
    assign mem_req_wen   = cap_store;
    assign mem_req_wdata = st_wdata;
    assign mem_req_wstrb = cap_store ? st_wstrb : STRB_NONE;

    // out_data is preloaded with in_res at accept; only a completed load overwrites it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_load     <= 1'b0;
            cap_store    <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_size     <= SZ_B;
            wd_cnt       <= '0;
            out_data     <= '0;
            out_rd       <= '0;
            out_rd_wen   <= 1'b0;
            out_misalign <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cap_addr     <= in_res;
                        cap_wdata    <= in_wdata;
                        cap_load     <= in_load;
                        cap_store    <= in_store;
                        cap_unsigned <= in_unsigned;
                        cap_size     <= in_size;
                        out_data     <= in_res;
                        out_rd       <= in_rd;
                        out_misalign <= 1'b0;
                        out_timeout  <= 1'b0;
                        if (!(in_load || in_store)) begin
                            out_rd_wen <= in_rd_wen;
                            state      <= ST_OUT;
                        end else if (is_misaligned(in_size, in_res[1:0])) begin
                            out_rd_wen   <= 1'b0;
                            out_misalign <= 1'b1;
                            state        <= ST_OUT;
                        end else begin
                            out_rd_wen <= in_load & in_rd_wen;
                            state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        wd_cnt <= '0;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        if (cap_load) begin
                            out_data <= ld_data;
                        end
                        state <= ST_OUT;
                    end else if (WD_EN && wd_cnt == WD_LAST) begin
                        out_timeout <= 1'b1;
                        out_rd_wen  <= 1'b0;
                        state       <= ST_OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed self-checking bench for lsu
module tb_lsu;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_res = '0;
    logic [31:0] in_wdata = '0;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_wen = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_misalign;
    logic        out_timeout;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_wdata(in_wdata),
        .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_rd_wen(out_rd_wen), .out_misalign(out_misalign), .out_timeout(out_timeout)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory / writeback behaviour knobs for the next transaction
    int          k_stall = 0;
    int          k_delay = 1;
    int          k_ostall = 0;
    logic [31:0] k_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] a, input logic u);
        logic [31:0] v;
        if (sz == 2'd2) return rd;
        if (sz == 2'd0) begin
            v = (rd >> (8 * a)) & 32'hFF;
            if (!u && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = (rd >> (8 * a)) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic bit f_mis(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && a != 0);
    endfunction

    // transaction-level reference model and recorded observations
    logic        m_busy = 0, m_req = 0, m_wait = 0, m_out = 0, m_zero = 1, m_seen = 0;
    int          m_wcnt = 0, accepts = 0;
    logic [31:0] t_res, t_wd;
    logic        t_ld, t_st, t_u;
    logic [1:0]  t_sz;
    logic [4:0]  t_rd;
    logic [31:0] e_data;
    logic        e_wen, e_mis, e_to;
    int          acc_edge, hs_edge, out_first, out_hs_edge;
    logic [31:0] r_addr, r_wdata, o_data;
    logic [3:0]  r_wstrb;
    logic        r_wen, o_wen, o_mis, o_to;

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, !m_busy);
            chk("mem_req_valid", mem_req_valid, m_req);
            if (m_req) begin
                chk("req_addr", mem_req_addr, t_res & 32'hFFFF_FFFC);
                chk("req_wen", mem_req_wen, t_st);
                chk("req_wstrb", mem_req_wstrb, t_st ? f_wstrb(t_sz, t_res[1:0]) : 4'h0);
                if (t_st) chk("req_wdata", mem_req_wdata, f_wdata(t_wd, t_sz));
            end
            chk("out_valid", out_valid, m_out);
            if (m_out) begin
                if (!m_seen) begin out_first = cyc; m_seen = 1; end
                chk("out_data", out_data, e_data);
                chk("out_rd", out_rd, t_rd);
                chk("out_rd_wen", out_rd_wen, e_wen);
                chk("out_misalign", out_misalign, e_mis);
                chk("out_timeout", out_timeout, e_to);
            end
            if (m_zero) begin
                chk("zero_out_data", out_data, 0);
                chk("zero_out_flags", {out_rd, out_rd_wen, out_misalign, out_timeout}, 0);
            end
            if (!rst_n) begin
                m_busy = 0; m_req = 0; m_wait = 0; m_out = 0; m_zero = 1;
            end else if (!m_busy) begin
                if (in_valid) begin
                    t_res = in_res; t_wd = in_wdata; t_ld = in_load; t_st = in_store;
                    t_sz = in_size; t_u = in_unsigned; t_rd = in_rd;
                    accepts++; acc_edge = cyc + 1; m_seen = 0; m_busy = 1; m_zero = 0;
                    e_data = in_res; e_mis = 0; e_to = 0;
                    if (!(t_ld || t_st)) begin
                        e_wen = in_rd_wen; m_out = 1;
                    end else if (f_mis(t_sz, t_res[1:0])) begin
                        e_wen = 0; e_mis = 1; m_out = 1;
                    end else begin
                        e_wen = t_ld & in_rd_wen; m_req = 1;
                    end
                end
            end else if (m_req) begin
                if (mem_req_ready) begin
                    r_addr = mem_req_addr; r_wdata = mem_req_wdata;
                    r_wstrb = mem_req_wstrb; r_wen = mem_req_wen;
                    hs_edge = cyc + 1; m_req = 0; m_wait = 1; m_wcnt = 0;
                end
            end else if (m_wait) begin
                if (mem_resp_valid) begin
                    if (t_ld) e_data = f_load(mem_resp_rdata, t_sz, t_res[1:0], t_u);
                    m_wait = 0; m_out = 1;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TIMEOUT) begin
                        e_to = 1; e_wen = 0; m_wait = 0; m_out = 1;
                    end
                end
            end else if (m_out && out_ready) begin
                o_data = out_data; o_wen = out_rd_wen; o_mis = out_misalign; o_to = out_timeout;
                out_hs_edge = cyc + 1; m_out = 0; m_busy = 0;
            end
        end
    end

    // memory responder: ready after k_stall cycles, response k_delay cycles after handshake
    initial begin
        int timer;
        int stall;
        bit hs;
        timer = 0; stall = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready && rst_n;
            @(posedge clk); #1;
            mem_resp_valid = 0;
            mem_resp_rdata = $urandom;
            if (hs) timer = (k_delay <= TIMEOUT) ? k_delay : 0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    mem_resp_valid = 1;
                    mem_resp_rdata = k_rdata;
                end
            end
            if (!mem_req_valid) begin
                stall = k_stall; mem_req_ready = 0;
            end else if (stall > 0) begin
                stall--; mem_req_ready = 0;
            end else begin
                mem_req_ready = 1;
            end
        end
    end

    initial begin
        int st;
        st = 0; out_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (!out_valid) begin
                st = k_ostall; out_ready = 1'($urandom_range(0, 1));
            end else if (st > 0) begin
                st--; out_ready = 0;
            end else begin
                out_ready = 1;
            end
        end
    end

    task automatic run_txn(input logic [31:0] res, input logic [31:0] wd, input logic ld,
                           input logic st, input logic [1:0] sz, input logic u,
                           input logic [4:0] rd, input logic wen, input bit wait_done);
        int n;
        logic ok;
        in_res = res; in_wdata = wd; in_load = ld; in_store = st; in_size = sz;
        in_unsigned = u; in_rd = rd; in_rd_wen = wen; in_valid = 1;
        n = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        chk("accept_seen", ok, 1);
        in_valid = 0; in_res = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
        in_load = 1'($urandom); in_store = 0; in_size = 2'($urandom);
        if (wait_done) begin
            n = 0;
            while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
            chk("txn_done", in_ready, 1);
        end
    endtask

    initial begin
        int a0;
        int n;
        logic seen;
        logic [1:0] kind;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // non-memory pass-through
        run_txn(32'h1234_5678, 0, 0, 0, 2'd2, 0, 5'd5, 1, 1);
        chk("nm_latency", out_first - acc_edge, 0);
        chk("nm_data", o_data, 32'h1234_5678);
        chk("nm_wen", o_wen, 1);

        // lb / lbu
        k_rdata = 32'h80AA_BBCC; k_delay = 2;
        run_txn(32'h8000_0003, 0, 1, 0, 2'd0, 0, 5'd7, 1, 1);
        chk("lb_addr", r_addr, 32'h8000_0000);
        chk("lb_wstrb", r_wstrb, 0);
        chk("lb_data", o_data, 32'hFFFF_FF80);
        chk("lb_resp_latency", out_first - hs_edge, 2);
        run_txn(32'h8000_0003, 0, 1, 0, 2'd0, 1, 5'd7, 1, 1);
        chk("lbu_data", o_data, 32'h0000_0080);

        // sh
        run_txn(32'h8000_0002, 32'hDEAD_BEEF, 0, 1, 2'd1, 0, 5'd9, 1, 1);
        chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);
        chk("sh_wstrb", r_wstrb, 4'b1100);
        chk("sh_wen", r_wen, 1);
        chk("sh_rd_wen", o_wen, 0);

        // misaligned lw
        run_txn(32'h8000_0001, 0, 1, 0, 2'd2, 0, 5'd3, 1, 1);
        chk("mis_flag", o_mis, 1);
        chk("mis_wen", o_wen, 0);
        chk("mis_latency", out_first - acc_edge, 0);

        // backpressure on both ports
        k_stall = 3; k_ostall = 2; k_delay = 1; a0 = accepts;
        run_txn(32'h0000_0040, 0, 1, 0, 2'd2, 0, 5'd1, 1, 1);
        chk("bp_req_hold", hs_edge - acc_edge, 4);
        chk("bp_out_hold", out_hs_edge - out_first, 3);
        chk("bp_accepts", accepts - a0, 1);
        k_stall = 0; k_ostall = 0;

        // watchdog
        k_delay = 6;
        run_txn(32'h0000_0080, 0, 1, 0, 2'd2, 0, 5'd2, 1, 1);
        chk("to_flag", o_to, 1);
        chk("to_wen", o_wen, 0);
        chk("to_latency", out_first - hs_edge, 4);

        // reset while waiting for a response; the late response must be ignored
        k_delay = 3;
        run_txn(32'h0000_0100, 0, 1, 0, 2'd2, 0, 5'd4, 1, 0);
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge clk); seen = mem_req_valid && mem_req_ready; n++;
        end
        chk("rst_hs_seen", seen, 1);
        @(posedge clk); #1; rst_n = 0;
        @(posedge clk); #1; rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("rr_out_valid", out_valid, 0);
            chk("rr_in_ready", in_ready, 1);
            chk("rr_out_data", out_data, 0);
        end
        @(posedge clk); #1;

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            k_stall = $urandom_range(0, 3);
            k_delay = $urandom_range(1, 6);
            k_ostall = $urandom_range(0, 2);
            k_rdata = $urandom;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            kind = 2'($urandom_range(0, 2));
            run_txn($urandom, $urandom, kind == 2'd1, kind == 2'd2, 2'($urandom),
                    1'($urandom), 5'($urandom), 1'($urandom), 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
